// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, taken-branch redirect,
// multi-cycle EX occupancy and dmem wait holds, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MULTI_CYCLES = 32,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             ex_multi_start,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             mem_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NSTG  = 4;
  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam int MCNT_W = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;
  localparam int WCNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MULTI_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(WAIT_TIMEOUT);
  localparam bit TO_EN = (WAIT_TIMEOUT != 0);

  typedef enum logic [1:0] {RUN, MULTI, MWAIT} state_t;

  typedef struct packed {
    logic            pc_en;
    logic [NSTG-1:0] stall;
    logic [NSTG-1:0] flush;
  } ctrl_t;

  state_t            state, state_nx;
  logic [MCNT_W-1:0] mcnt, mcnt_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  ctrl_t             ctl;
  logic [NSTG-1:0]   flush_eff;
  logic              timeout;
  logic              mem_hold;
  logic              load_use;

  assign mem_hold = mem_req && !dmem_ready;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nx  = state;
    mcnt_nx   = mcnt;
    wcnt_nx   = wcnt;
    ctl.pc_en = 1'b1;
    ctl.stall = '0;
    ctl.flush = '0;
    timeout   = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_hold) begin
          ctl.stall = '1;
          ctl.pc_en = 1'b0;
          state_nx  = MWAIT;
          wcnt_nx   = WCNT_W'(1);
        end else if (ex_br_taken) begin
          // redirect: PC takes the target, younger wrong-path work is dropped
          ctl.flush[IFID] = 1'b1;
          ctl.flush[IDEX] = 1'b1;
        end else begin
          if (load_use) begin
            ctl.stall[IFID] = 1'b1;
            ctl.flush[IDEX] = 1'b1;
            ctl.pc_en       = 1'b0;
          end
          if (ex_multi_start) begin
            state_nx = MULTI;
            mcnt_nx  = MCNT_INIT;
          end
        end
      end
      MULTI: begin
        ctl.pc_en = 1'b0;
        if (mem_hold) begin
          // older op still waiting on dmem: freeze everything, including mcnt
          ctl.stall = '1;
        end else begin
          ctl.stall[IFID]  = 1'b1;
          ctl.stall[IDEX]  = 1'b1;
          ctl.flush[EXMEM] = 1'b1;
          mcnt_nx = mcnt - MCNT_W'(1);
          if (mcnt == MCNT_W'(1)) state_nx = RUN;
        end
      end
      MWAIT: begin
        ctl.stall = '1;
        ctl.pc_en = 1'b0;
        if (mem_req && dmem_ready) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else if (TO_EN && (wcnt == WCNT_MAX)) begin
          // abort: drop the stuck access instead of holding MEM/WB
          timeout          = 1'b1;
          ctl.stall[MEMWB] = 1'b0;
          ctl.flush[MEMWB] = 1'b1;
          state_nx         = RUN;
          wcnt_nx          = '0;
        end else if (wcnt != '1) begin
          wcnt_nx = wcnt + WCNT_W'(1);
        end
      end
      default: state_nx = RUN;
    endcase
    if (!rst) begin
      ctl.pc_en = 1'b0;
      ctl.stall = '0;
      ctl.flush = '1;
      timeout   = 1'b0;
    end
  end

  assign flush_eff   = ctl.flush & ~ctl.stall;
  assign pc_en       = ctl.pc_en;
  assign stall_ifid  = ctl.stall[IFID];
  assign stall_idex  = ctl.stall[IDEX];
  assign stall_exmem = ctl.stall[EXMEM];
  assign stall_memwb = ctl.stall[MEMWB];
  assign flush_ifid  = flush_eff[IFID];
  assign flush_idex  = flush_eff[IDEX];
  assign flush_exmem = flush_eff[EXMEM];
  assign flush_memwb = flush_eff[MEMWB];
  assign mem_timeout = timeout;
  assign busy        = rst && (state != RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      mcnt      <= '0;
      wcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
      wcnt  <= wcnt_nx;
      if (!ctl.pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MULTI_CYCLES=4, WAIT_TIMEOUT=8, CNT_W=4.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_multi_start;
  logic       mem_req, dmem_ready;
  logic       pc_en, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb, mem_timeout, busy;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULTI_CYCLES(4), .WAIT_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .ex_multi_start(ex_multi_start), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en),
    .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .mem_timeout(mem_timeout), .busy(busy), .stall_cnt(stall_cnt)
  );

  // {pc_en, stall if/id/ex/mem, flush if/id/ex/mem, mem_timeout, busy}
  logic [10:0] obs;
  assign obs = {pc_en, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                flush_ifid, flush_idex, flush_exmem, flush_memwb, mem_timeout, busy};

  localparam logic [10:0] IDLE  = 11'b1_0000_0000_00;
  localparam logic [10:0] RSTO  = 11'b0_0000_1111_00;
  localparam logic [10:0] LU    = 11'b0_1000_0100_00;
  localparam logic [10:0] BR    = 11'b1_0000_1100_00;
  localparam logic [10:0] MUL   = 11'b0_1100_0010_01;
  localparam logic [10:0] MEMS  = 11'b0_1111_0000_00;
  localparam logic [10:0] MWAIT = 11'b0_1111_0000_01;
  localparam logic [10:0] TMO   = 11'b0_1110_0001_11;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0; ex_multi_start = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic do_reset();
    nxt(); rst = 1'b0; idle_in();
    nxt(); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_in();
    nxt();
    set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    ex_br_taken = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== RSTO) begin n_bad++; $display("FAIL reset_out: got %b want %b", obs, RSTO); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    nxt(); rst = 1'b1; idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs, IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5, 5'd5, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (obs !== LU) begin n_bad++; $display("FAIL lu_rs1: got %b want %b", obs, LU); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL lu_clean: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
    nxt(); set_lu(5'd5, 5'd1, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (obs !== LU) begin n_bad++; $display("FAIL lu_rs2: got %b want %b", obs, LU); end
    nxt(); set_lu(5'd5, 5'd1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL lu_unused_rs2: got %b want %b", obs, IDLE); end
    nxt(); set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL lu_x0: got %b want %b", obs, IDLE); end
    nxt(); set_lu(5'd7, 5'd7, 5'd0, 1'b1, 1'b0); ex_mem_read = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL lu_not_load: got %b want %b", obs, IDLE); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL lu_cnt2: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    set_lu(5'd9, 5'd9, 5'd0, 1'b1, 1'b0); ex_br_taken = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== BR) begin n_bad++; $display("FAIL br_over_lu: got %b want %b", obs, BR); end
    nxt(); idle_in(); ex_br_taken = 1'b1; ex_multi_start = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== BR) begin n_bad++; $display("FAIL br_with_multi: got %b want %b", obs, BR); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL br_no_multi: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL br_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_multi();
    do_reset();
    ex_multi_start = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL mul_entry: got %b want %b", obs, IDLE); end
    for (int i = 0; i < 3; i++) begin
      nxt(); idle_in();
      if (i == 1) begin set_lu(5'd4, 5'd4, 5'd0, 1'b1, 1'b0); ex_br_taken = 1'b1; end
      @(negedge clk);
      n_cmp++; if (obs !== MUL) begin n_bad++; $display("FAIL mul_cyc%0d: got %b want %b", i, obs, MUL); end
    end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL mul_exit: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd3) begin n_bad++; $display("FAIL mul_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== MEMS) begin n_bad++; $display("FAIL mem_entry: got %b want %b", obs, MEMS); end
    for (int i = 0; i < 4; i++) begin
      nxt(); ex_br_taken = (i == 1);
      @(negedge clk);
      n_cmp++; if (obs !== MWAIT) begin n_bad++; $display("FAIL mem_wait%0d: got %b want %b", i, obs, MWAIT); end
    end
    nxt(); ex_br_taken = 1'b0; dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== MWAIT) begin n_bad++; $display("FAIL mem_done: got %b want %b", obs, MWAIT); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL mem_exit: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd6) begin n_bad++; $display("FAIL mem_cnt: got %0d want 6", stall_cnt); end
  endtask

  task automatic test_multi_mem();
    do_reset();
    ex_multi_start = 1'b1;
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== MUL) begin n_bad++; $display("FAIL mm_first: got %b want %b", obs, MUL); end
    for (int i = 0; i < 2; i++) begin
      nxt(); mem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (obs !== MWAIT) begin n_bad++; $display("FAIL mm_hold%0d: got %b want %b", i, obs, MWAIT); end
    end
    nxt(); dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== MUL) begin n_bad++; $display("FAIL mm_resume: got %b want %b", obs, MUL); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== MUL) begin n_bad++; $display("FAIL mm_last: got %b want %b", obs, MUL); end
    nxt();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL mm_exit: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd5) begin n_bad++; $display("FAIL mm_cnt: got %0d want 5", stall_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== MEMS) begin n_bad++; $display("FAIL to_entry: got %b want %b", obs, MEMS); end
    for (int i = 1; i < 8; i++) begin
      nxt();
      @(negedge clk);
      n_cmp++; if (obs !== MWAIT) begin n_bad++; $display("FAIL to_wait%0d: got %b want %b", i, obs, MWAIT); end
    end
    nxt();
    @(negedge clk);
    n_cmp++; if (obs !== TMO) begin n_bad++; $display("FAIL to_pulse: got %b want %b", obs, TMO); end
    nxt(); idle_in();
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL to_exit: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd9) begin n_bad++; $display("FAIL to_cnt: got %0d want 9", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ex_multi_start = 1'b1;
    nxt(); idle_in();
    nxt(); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== RSTO) begin n_bad++; $display("FAIL rm_out: got %b want %b", obs, RSTO); end
    nxt(); rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== IDLE) begin n_bad++; $display("FAIL rm_run: got %b want %b", obs, IDLE); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL rm_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 14; i++) nxt();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 4'd14) begin n_bad++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
    nxt();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_15: got %0d want 15", stall_cnt); end
    for (int i = 0; i < 5; i++) nxt();
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
    nxt(); idle_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multi();
    test_mem_stall();
    test_multi_mem();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
